// File: rtl/ika9958_vram_slot.sv
// VRAM slot sequencer: arbitrates display, CPU and refresh accesses into 8-phase
// DRAM slots and drives the RAS/CAS/WE strobes and the multiplexed row/column address.
module ika9958_vram_slot (
    input  logic        phiA,
    input  logic        RST_async_n,
    input  logic        phiL_NCEN,
    input  logic [7:0]  cpc_z_of_m8c,
    input  logic        disp_req,
    input  logic [16:0] disp_addr,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        cpu_req,
    input  logic [16:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ref_tick,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nWE,
    output logic [8:0]  ma,
    output logic [7:0]  md_o,
    output logic        md_oe,
    input  logic [7:0]  md_i
);

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_DISP, SLOT_CPU, SLOT_REFR} slot_t;

    slot_t       r_slot;
    logic        r_active;
    logic [7:0]  r_addr_lo;
    logic        r_we;
    logic [7:0]  r_wdata;
    logic [1:0]  r_ref_pend;
    logic [7:0]  r_ref_row;
    logic        r_cpu_done;

    logic        r_nras, r_ncas, r_nwe, r_md_oe, r_cpu_ack, r_disp_valid;
    logic [8:0]  r_ma;
    logic [7:0]  r_md_o, r_disp_data, r_cpu_rdata;

    logic        w_ph_vld;
    logic [2:0]  w_ph;
    slot_t       w_sel;
    logic        w_ref_done;
    logic [1:0]  w_pend_next;

    // Several strobe bits at once collapse to the lowest phase.
    always_comb begin
        w_ph_vld = |cpc_z_of_m8c;
        w_ph     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cpc_z_of_m8c[i]) w_ph = 3'(i);
        end
    end

    always_comb begin
        w_sel = SLOT_IDLE;
        if (disp_req)                       w_sel = SLOT_DISP;
        else if (r_ref_pend == 2'd3)        w_sel = SLOT_REFR;
        else if (cpu_req && !r_cpu_done)    w_sel = SLOT_CPU;
        else if (r_ref_pend != 2'd0)        w_sel = SLOT_REFR;
    end

    always_comb begin
        w_ref_done  = w_ph_vld && (w_ph == 3'd7) && r_active && (r_slot == SLOT_REFR);
        w_pend_next = r_ref_pend;
        if (ref_tick && !w_ref_done && r_ref_pend != 2'd3) w_pend_next = r_ref_pend + 2'd1;
        else if (!ref_tick && w_ref_done)                  w_pend_next = r_ref_pend - 2'd1;
    end

    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            r_slot       <= SLOT_IDLE;
            r_active     <= 1'b0;
            r_addr_lo    <= 8'd0;
            r_we         <= 1'b0;
            r_wdata      <= 8'd0;
            r_ref_pend   <= 2'd0;
            r_ref_row    <= 8'd0;
            r_cpu_done   <= 1'b0;
            r_nras       <= 1'b1;
            r_ncas       <= 1'b1;
            r_nwe        <= 1'b1;
            r_md_oe      <= 1'b0;
            r_ma         <= 9'd0;
            r_md_o       <= 8'd0;
            r_disp_data  <= 8'd0;
            r_cpu_rdata  <= 8'd0;
            r_cpu_ack    <= 1'b0;
            r_disp_valid <= 1'b0;
        end else if (phiL_NCEN) begin
            r_cpu_ack    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_ref_pend   <= w_pend_next;
            if (!cpu_req) r_cpu_done <= 1'b0;

            if (w_ph_vld && w_ph == 3'd0) begin
                if (r_active) begin
                    // Phase 0 cut the previous slot short: release the bus, leave requests pending.
                    r_nras   <= 1'b1;
                    r_ncas   <= 1'b1;
                    r_nwe    <= 1'b1;
                    r_md_oe  <= 1'b0;
                    r_slot   <= SLOT_IDLE;
                    r_active <= 1'b0;
                end else begin
                    r_slot   <= w_sel;
                    r_active <= (w_sel != SLOT_IDLE);
                    case (w_sel)
                        SLOT_DISP: begin
                            r_addr_lo <= disp_addr[7:0];
                            r_we      <= 1'b0;
                            r_nras    <= 1'b0;
                            r_ma      <= disp_addr[16:8];
                        end
                        SLOT_CPU: begin
                            r_addr_lo <= cpu_addr[7:0];
                            r_we      <= cpu_we;
                            r_wdata   <= cpu_wdata;
                            r_nras    <= 1'b0;
                            r_ma      <= cpu_addr[16:8];
                        end
                        SLOT_REFR: begin
                            r_nras <= 1'b0;
                            r_ma   <= {1'b0, r_ref_row};
                        end
                        default: ;
                    endcase
                end
            end else if (w_ph_vld && r_active) begin
                case (w_ph)
                    3'd2: begin
                        if (r_slot == SLOT_DISP || r_slot == SLOT_CPU) begin
                            r_ma   <= {1'b0, r_addr_lo};
                            r_ncas <= 1'b0;
                        end
                    end
                    3'd3: begin
                        if (r_slot == SLOT_CPU && r_we) begin
                            r_nwe      <= 1'b0;
                            r_md_oe    <= 1'b1;
                            r_md_o     <= r_wdata;
                            r_cpu_ack  <= 1'b1;
                            r_cpu_done <= 1'b1;
                        end
                    end
                    3'd5: begin
                        if (r_slot == SLOT_DISP) begin
                            r_disp_data  <= md_i;
                            r_disp_valid <= 1'b1;
                        end else if (r_slot == SLOT_CPU && !r_we) begin
                            r_cpu_rdata <= md_i;
                            r_cpu_ack   <= 1'b1;
                            r_cpu_done  <= 1'b1;
                        end
                    end
                    3'd6: begin
                        r_ncas  <= 1'b1;
                        r_nwe   <= 1'b1;
                        r_md_oe <= 1'b0;
                    end
                    3'd7: begin
                        r_nras   <= 1'b1;
                        r_active <= 1'b0;
                        r_slot   <= SLOT_IDLE;
                        if (r_slot == SLOT_REFR) r_ref_row <= r_ref_row + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign nRAS       = r_nras;
    assign nCAS       = r_ncas;
    assign nWE        = r_nwe;
    assign md_oe      = r_md_oe;
    assign ma         = r_ma;
    assign md_o       = r_md_o;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ack    = r_cpu_ack;

endmodule

// File: doc/ika9958_vram_slot.md
IKA9958_VRAM_SLOT -- requirements
Module: ika9958_vram_slot

Interface
REQ-001 phiA  in  1  master clock; all state updates on posedge phiA, gated by phiL_NCEN.
REQ-002 RST_async_n  in  1  asynchronous active-low reset.
REQ-003 phiL_NCEN  in  1  clock enable; state advances only when high ("tick").
REQ-004 cpc_z_of_m8c  in  8  one-hot slot-phase strobes from the common PLA, bit n = phase n of the 8-cycle slot.
REQ-005 disp_req  in  1  display fetch request, sampled at phase 0 only.
REQ-006 disp_addr  in  17  display fetch address, sampled at phase 0.
REQ-007 disp_data / disp_valid  out  8 / 1  fetched byte; one-tick valid strobe.
REQ-008 cpu_req  in  1  CPU access request level, held with cpu_addr, cpu_we and cpu_wdata until cpu_ack.
REQ-009 cpu_addr / cpu_we / cpu_wdata  in  17 / 1 / 8  CPU address, write flag and write data.
REQ-010 cpu_ack / cpu_rdata  out  1 / 8  one-tick completion strobe; read data valid during cpu_ack.
REQ-011 ref_tick  in  1  one-tick refresh-due pulse.
REQ-012 nRAS / nCAS / nWE  out  1 each  DRAM strobes, active low.
REQ-013 ma / md_o / md_oe / md_i  out 9 / out 8 / out 1 / in 8  multiplexed DRAM address, write data, output enable, read data.

Function
REQ-014 Slot type is latched on the tick where cpc_z_of_m8c[0]=1; priority order is DISP, then REFRESH if ref_pend==3, then CPU, then REFRESH if ref_pend>0, then IDLE.
REQ-015 DISP is selected when disp_req=1; CPU is selected when cpu_req=1 and no CPU ack is outstanding.
REQ-016 Strobe schedule by phase tick (DISP/CPU): ph0 nRAS=0, ma=addr[16:8]; ph2 ma={1'b0,addr[7:0]}, nCAS=0.
REQ-017 ph3: CPU write sets nWE=0, md_oe=1, md_o=cpu_wdata, and asserts cpu_ack.
REQ-018 ph5: a read latches md_i into disp_data with disp_valid=1 (DISP), or into cpu_rdata with cpu_ack=1 (CPU read).
REQ-019 ph6 sets nCAS=1, nWE=1, md_oe=0; ph7 sets nRAS=1.
REQ-020 REFRESH is RAS-only: ph0 nRAS=0 with ma={1'b0,ref_row}; ph7 nRAS=1; ref_row (8 bit) increments and wraps 255->0; ref_pend decrements.
REQ-021 IDLE drives no strobes; ma holds its last value.
REQ-022 ref_pend is a 2-bit saturating counter incremented by ref_tick; simultaneous ref_tick and refresh completion leave it unchanged; ref_tick at ref_pend==3 is dropped.
REQ-023 An ack/valid outputs are registered strobes, high for exactly one tick, and low otherwise.
REQ-024 cpu_ack is never asserted twice for one request; after an ack, CPU is ineligible until cpu_req has been low for at least one tick.
REQ-025 Abort: phase 0 arriving while the previous slot has not reached ph7 (e.g. text-mode-suppressed phases) forces nRAS=nCAS=nWE=1 and md_oe=0 on that tick; the new slot is IDLE.
REQ-026 On abort, no ack or valid strobe is issued, CPU and refresh requests remain pending, and ref_row is not advanced.
REQ-027 Phase strobes with no active slot are ignored; multiple bits set at once are treated as the lowest set bit.
REQ-028 disp_addr and cpu_addr are captured at ph0; later changes do not affect the current slot.

Reset
REQ-029 Asynchronous reset forces nRAS=nCAS=nWE=1, md_oe=0, ma=0, md_o=0, disp_data=0, cpu_rdata=0, disp_valid=0, cpu_ack=0, ref_pend=0, ref_row=0, slot=IDLE.
REQ-030 Reset asserted mid-slot deasserts all DRAM strobes immediately, without waiting for phiA.
REQ-031 The first slot after reset release starts at the next phase 0.

Verification
REQ-032 cpu_req=1, cpu_we=0, cpu_addr=0x1_2345, md_i=0xA5 -> ma=0x123 at ph0, ma=0x045 at ph2, cpu_ack and cpu_rdata=0xA5 at ph5, nRAS high after ph7.
REQ-033 cpu_we=1, cpu_wdata=0x3C -> nWE=0, md_oe=1, md_o=0x3C and cpu_ack at ph3; nWE=1 at ph6; exactly one ack while cpu_req is held 3 slots.
REQ-034 disp_req and cpu_req both high -> slot1 DISP (disp_valid at ph5), CPU served only in the first slot with disp_req=0.
REQ-035 Three ref_tick pulses with continuous cpu_req -> next slot REFRESH ahead of CPU, ma=0x000, ref_pend=2; a 4th tick at pend 3 is not counted.
REQ-036 Phase 0 injected after ph4 of a CPU read -> all strobes high that tick, no cpu_ack, CPU is re-served in the following slot.
REQ-037 RST_async_n pulled low at ph3 of a write -> nRAS, nCAS and nWE high asynchronously, all outputs at reset values, ref_row=0.
